bytecode_prefetch_unit: RTL and testbench
=========================================

// Module: bytecode_prefetch_unit
// PURPOSE
//  Parametrised JVM bytecode fetch front-end that supersedes the single-byte PC fetcher.
//  Drives a jvm_memory-style start/ready port and fills a DEPTH-entry prefetch FIFO of {byte, pc}.
//  The downstream decoder consumes entries with a valid/take handshake.
//  Supports redirect on jump/branch (flush plus discard of any in-flight read), enable/stall,
//  and a configurable reset PC.
// PARAMETERS
//  ADDRESS_WIDTH  8     width of PC / memory address; PC wraps mod 2**ADDRESS_WIDTH
//  DATA_WIDTH     8     width of one bytecode word returned by memory
//  DEPTH          4     prefetch FIFO entries; power of two, >=2
//  RESET_PC       0     fetch address loaded on reset
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  enable       in   1   1 = new memory requests may be issued
//  jump         in   1   one-cycle redirect strobe
//  jump_target  in   AW  new fetch address, sampled when jump=1
//  mem_address  out  AW  read address to memory
//  mem_start    out  1   read request; held high until mem_ready
//  mem_data     in   DW  read data, valid when mem_ready=1
//  mem_ready    in   1   one-cycle completion pulse from memory
//  byte_out     out  DW  FIFO head data
//  byte_pc      out  AW  address of FIFO head
//  byte_valid   out  1   FIFO non-empty
//  byte_take    in   1   consumer pops head when byte_valid=1
//  fetch_pc     out  AW  next address to be requested (debug)
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, count=0, rd/wr ptrs=0, fetch_pc=RESET_PC.
//   Outputs: mem_start=0, byte_valid=0, byte_out=0, byte_pc=0, mem_address=RESET_PC.
//  FSM states: IDLE, FETCH, DISCARD.
//   IDLE -> FETCH when enable=1 and count<DEPTH and jump=0.
//    mem_start=1 and mem_address=fetch_pc are registered on entry.
//   FETCH: hold mem_start and mem_address stable until mem_ready.
//    On mem_ready: push {mem_data, mem_address}; fetch_pc <= fetch_pc+1 (wraps).
//    Then issue the next request immediately (stay in FETCH, address+1) if enable=1 and the
//    post-update count<DEPTH; otherwise go to IDLE with mem_start=0.
//   DISCARD: mem_start held until mem_ready; returned data dropped, no push.
//    Then FETCH at fetch_pc if enable=1, else IDLE.
//  Issue rule: a request is only issued when the FIFO has a free slot for it, so a push never
//   overflows. At most one read is outstanding.
//  Pop: byte_take=1 and byte_valid=1 advances rd ptr; byte_take with byte_valid=0 is ignored.
//   Push and pop in the same cycle leave count unchanged, including at count=DEPTH.
//  Jump (priority over all else): FIFO flushed (count=0, ptrs=0); fetch_pc <= jump_target.
//   byte_take and any coinciding push are ignored that cycle.
//   If a request is outstanding and mem_ready=0 -> DISCARD.
//   If mem_ready=1 in the jump cycle, its data is dropped and the FSM goes to FETCH/IDLE.
//   The first valid byte after a jump always has byte_pc=jump_target.
//  enable=0: no new requests; an in-flight read completes and is pushed normally.
//  Latency: request issued the cycle after the IDLE->FETCH decision; a byte pushed on
//   mem_ready is visible (byte_valid=1) the following cycle.
//  byte_out/byte_pc are combinational from FIFO head; contents undefined when byte_valid=0.
//  PC wrap: fetch_pc = 2**AW-1 fetches, then wraps to 0 with no flag.
// TESTING
//  1 Reset with mem returning mem[a]=a+8'h10, 1-cycle ready, enable=1, no take.
//    -> FIFO fills with pcs 0..3 and data 10..13; mem_start=0 once count=4.
//  2 From full FIFO, byte_take held 1 for 6 cycles.
//    -> bytes popped in order pc 0,1,2...; refills continue; no lost or duplicated pc.
//  3 jump=1, target=8'h40, while a 3-cycle read of pc 5 is outstanding.
//    -> byte_valid=0 next cycle; pc5 data dropped; next valid byte_pc=40, data=50.
//  4 RESET_PC=8'hFE, take every cycle.
//    -> byte_pc sequence FE, FF, 00, 01.
//  5 enable dropped mid-read.
//    -> that read completes and is pushed; no further mem_start until enable=1.
//  6 reset asserted mid-FETCH with count=2.
//    -> outputs cleared immediately (async); restart fetches from RESET_PC.

Source files
------------

// File: rtl/bytecode_prefetch_unit_if.sv
// Bundle of the memory read port and the decoder-facing byte port of the
// bytecode prefetch unit.
//   mem_address / mem_start : read request toward memory (held until mem_ready)
//   mem_data / mem_ready    : read data and one-cycle completion pulse
//   byte_out / byte_pc      : FIFO head data and its address
//   byte_valid / byte_take  : FIFO non-empty / consumer pop strobe
// Modports: master = prefetch unit side, slave = memory + decoder side.
interface bytecode_prefetch_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_start;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    byte_out;
  logic [ADDRESS_WIDTH-1:0] byte_pc;
  logic                     byte_valid;
  logic                     byte_take;

  modport master (
    output mem_address, mem_start, byte_out, byte_pc, byte_valid,
    input  mem_data, mem_ready, byte_take
  );

  modport slave (
    input  mem_address, mem_start, byte_out, byte_pc, byte_valid,
    output mem_data, mem_ready, byte_take
  );
endinterface

// File: rtl/bytecode_prefetch_unit.sv
// JVM bytecode fetch front-end. Issues single reads on a start/ready memory
// port and fills a DEPTH-entry FIFO of {byte, pc} consumed by the decoder.
// A jump flushes the FIFO and retargets fetching; a read still in flight at
// the jump is completed and its data dropped (DISCARD state).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       1 = new memory requests may be issued
//   jump         one-cycle redirect strobe
//   jump_target  new fetch address, sampled when jump=1
//   fetch_pc     next address to be requested (debug)
//   bus          memory request/response and FIFO head/take (master modport)
module bytecode_prefetch_unit #(
  parameter int unsigned              ADDRESS_WIDTH = 8,
  parameter int unsigned              DATA_WIDTH    = 8,
  parameter int unsigned              DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     jump,
  input  logic [ADDRESS_WIDTH-1:0] jump_target,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc,
  bytecode_prefetch_unit_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]         FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]         PTR_ONE = PTR_W'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE  = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t                   state, state_next;
  logic                     start_r, start_next;
  logic [ADDRESS_WIDTH-1:0] address_r, address_next;
  logic [ADDRESS_WIDTH-1:0] pc_next, resume_pc;

  logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]         rd_ptr, wr_ptr;
  logic [CNT_W-1:0]         count, count_after;
  logic                     push, pop;

  // FIFO bookkeeping; jump overrides any push/pop in the same cycle.
  always_comb begin
    pop  = bus.byte_take && (count != '0) && !jump;
    push = (state == FETCH) && bus.mem_ready && !jump;
    count_after = count;
    if (jump) begin
      count_after = '0;
    end else begin
      if (push) count_after = count_after + CNT_ONE;
      if (pop)  count_after = count_after - CNT_ONE;
    end
  end

  // Next-state logic. A request is only issued when the post-update count
  // leaves a free slot, so the single outstanding read can always be pushed.
  always_comb begin
    state_next   = state;
    start_next   = start_r;
    address_next = address_r;
    pc_next      = fetch_pc;
    resume_pc    = fetch_pc;
    case (state)
      IDLE: begin
        if (jump) begin
          pc_next = jump_target;
        end else if (enable && (count < FULL)) begin
          state_next   = FETCH;
          start_next   = 1'b1;
          address_next = fetch_pc;
        end
      end
      FETCH, DISCARD: begin
        if (jump)                 resume_pc = jump_target;
        else if (state == FETCH)  resume_pc = fetch_pc + PC_ONE;
        if (bus.mem_ready) begin
          pc_next = resume_pc;
          if (enable && (count_after < FULL)) begin
            state_next   = FETCH;
            start_next   = 1'b1;
            address_next = resume_pc;
          end else begin
            state_next = IDLE;
            start_next = 1'b0;
          end
        end else if (jump) begin
          // Request stays asserted; its data will be dropped when it returns.
          state_next = DISCARD;
          pc_next    = jump_target;
        end
      end
      default: begin
        state_next = IDLE;
        start_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_r   <= 1'b0;
      address_r <= RESET_PC;
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      state     <= state_next;
      start_r   <= start_next;
      address_r <= address_next;
      fetch_pc  <= pc_next;
      count     <= count_after;
      if (jump) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_data;
      fifo_pc[wr_ptr]   <= address_r;
    end
  end

  // Head is forced to zero when empty so the outputs are defined after reset.
  assign bus.mem_start   = start_r;
  assign bus.mem_address = address_r;
  assign bus.byte_valid  = (count != '0);
  assign bus.byte_out    = (count != '0) ? fifo_data[rd_ptr] : '0;
  assign bus.byte_pc     = (count != '0) ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_bytecode_prefetch_unit.sv
module tb_bytecode_prefetch_unit;

  logic       clk;
  logic       rst0, rst1;
  logic       en0, en1, jump0, jump1;
  logic [7:0] tgt0, tgt1, fpc0, fpc1;

  int tests = 0;
  int fails = 0;

  bytecode_prefetch_unit_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) if0 ();
  bytecode_prefetch_unit_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) if1 ();

  bytecode_prefetch_unit #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)
  ) dut0 (
    .clk(clk), .reset(rst0), .enable(en0), .jump(jump0),
    .jump_target(tgt0), .fetch_pc(fpc0), .bus(if0)
  );

  bytecode_prefetch_unit #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(8'hFE)
  ) dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .jump(jump1),
    .jump_target(tgt1), .fetch_pc(fpc1), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: mem[a] = a + 8'h10, ready pulse lat cycles after request.
  int   lat0 = 1;
  int   cnt0, cnt1;
  logic busy0, busy1;

  always @(negedge clk) begin
    if (!rst0) begin
      if0.mem_ready = 1'b0;
      if0.mem_data  = 8'h00;
      busy0 = 1'b0;
    end else begin
      if (if0.mem_ready) begin
        if0.mem_ready = 1'b0;
        busy0 = 1'b0;
      end
      if (!busy0 && if0.mem_start) begin
        busy0 = 1'b1;
        cnt0  = lat0;
      end
      if (busy0 && !if0.mem_ready) begin
        cnt0 = cnt0 - 1;
        if (cnt0 == 0) begin
          if0.mem_ready = 1'b1;
          if0.mem_data  = if0.mem_address + 8'h10;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1) begin
      if1.mem_ready = 1'b0;
      if1.mem_data  = 8'h00;
      busy1 = 1'b0;
    end else begin
      if (if1.mem_ready) begin
        if1.mem_ready = 1'b0;
        busy1 = 1'b0;
      end
      if (!busy1 && if1.mem_start) begin
        busy1 = 1'b1;
        cnt1  = 1;
      end
      if (busy1 && !if1.mem_ready) begin
        cnt1 = cnt1 - 1;
        if (cnt1 == 0) begin
          if1.mem_ready = 1'b1;
          if1.mem_data  = if1.mem_address + 8'h10;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       en;
    logic       take;
    logic       start;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
    logic [7:0] data;
    logic [7:0] fpc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       found;
    logic       seen;
    int         n;
    logic [7:0] got_pc   [4];
    logic [7:0] got_data [4];
    logic [7:0] exp_pc   [4];
    logic [7:0] exp_data [4];

    // Fill then drain with continuous refill; 1-cycle memory.
    //            en take start addr  valid pc     data   fetch_pc
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h10, 8'h01};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 8'h10, 8'h02};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 8'h10, 8'h03};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h10, 8'h04};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h10, 8'h04};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h11, 8'h04};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 8'h12, 8'h04};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03, 8'h13, 8'h05};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 8'h04, 8'h14, 8'h06};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 8'h05, 8'h15, 8'h07};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h08, 1'b1, 8'h06, 8'h16, 8'h08};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 8'h06, 8'h16, 8'h09};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 8'h16, 8'h0A};

    rst0 = 1'b0; rst1 = 1'b0;
    en0 = 1'b0; jump0 = 1'b0; tgt0 = 8'h00;
    en1 = 1'b1; jump1 = 1'b0; tgt1 = 8'h00;
    if0.byte_take = 1'b0;
    if1.byte_take = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start",   {31'b0, if0.mem_start},  0);
    chk("rst_valid",   {31'b0, if0.byte_valid}, 0);
    chk("rst_addr",    {24'b0, if0.mem_address}, 32'h00);
    chk("rst_byte",    {24'b0, if0.byte_out},   32'h00);
    chk("rst_pc",      {24'b0, if0.byte_pc},    32'h00);
    chk("rst1_addr",   {24'b0, if1.mem_address}, 32'hFE);
    chk("rst1_fpc",    {24'b0, fpc1},           32'hFE);
    rst0 = 1'b1;

    // Tests 1/2: table-driven fill and drain.
    for (int i = 0; i < 14; i++) begin
      en0 = vecs[i].en;
      if0.byte_take = vecs[i].take;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_start", i), {31'b0, if0.mem_start}, {31'b0, vecs[i].start});
      if (vecs[i].start)
        chk($sformatf("v%0d_addr", i), {24'b0, if0.mem_address}, {24'b0, vecs[i].addr});
      chk($sformatf("v%0d_valid", i), {31'b0, if0.byte_valid}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i),   {24'b0, if0.byte_pc},  {24'b0, vecs[i].pc});
        chk($sformatf("v%0d_data", i), {24'b0, if0.byte_out}, {24'b0, vecs[i].data});
      end
      chk($sformatf("v%0d_fpc", i), {24'b0, fpc0}, {24'b0, vecs[i].fpc});
    end
    if0.byte_take = 1'b0;

    // Test 6: async reset mid-FETCH with two entries buffered.
    rst0 = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_valid", {31'b0, if0.byte_valid}, 1);
    chk("t6_pre_addr",  {24'b0, if0.mem_address}, 32'h02);
    #1 rst0 = 1'b0;
    #1;
    chk("t6_start", {31'b0, if0.mem_start},  0);
    chk("t6_valid", {31'b0, if0.byte_valid}, 0);
    chk("t6_byte",  {24'b0, if0.byte_out},   32'h00);
    chk("t6_pc",    {24'b0, if0.byte_pc},    32'h00);
    chk("t6_fpc",   {24'b0, fpc0},           32'h00);
    @(posedge clk); @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_restart_start", {31'b0, if0.mem_start}, 1);
    chk("t6_restart_addr",  {24'b0, if0.mem_address}, 32'h00);
    @(posedge clk);
    #1;
    chk("t6_first_pc",   {24'b0, if0.byte_pc},  32'h00);
    chk("t6_first_data", {24'b0, if0.byte_out}, 32'h10);

    // Test 3: jump while a 3-cycle read of pc 5 is outstanding.
    rst0 = 1'b0;
    lat0 = 3;
    @(posedge clk); @(posedge clk);
    #1;
    rst0 = 1'b1;
    if0.byte_take = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk);
      #1;
      if (if0.mem_start && if0.mem_address == 8'h05) found = 1'b1;
    end
    chk("t3_reach_pc5", {31'b0, found}, 1);
    jump0 = 1'b1; tgt0 = 8'h40;
    @(posedge clk);
    #1;
    jump0 = 1'b0;
    chk("t3_flush_valid", {31'b0, if0.byte_valid}, 0);
    chk("t3_fpc",         {24'b0, fpc0}, 32'h40);
    chk("t3_hold_start",  {31'b0, if0.mem_start}, 1);
    chk("t3_hold_addr",   {24'b0, if0.mem_address}, 32'h05);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk);
      #1;
      if (if0.byte_valid) found = 1'b1;
    end
    chk("t3_got_byte", {31'b0, found}, 1);
    chk("t3_pc",   {24'b0, if0.byte_pc},  32'h40);
    chk("t3_data", {24'b0, if0.byte_out}, 32'h50);

    // Test 5: drop enable while the read of 0x41 is in flight.
    en0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (if0.byte_valid && if0.byte_pc == 8'h41) found = 1'b1;
    end
    chk("t5_got_byte", {31'b0, found}, 1);
    chk("t5_data",     {24'b0, if0.byte_out}, 32'h51);
    chk("t5_fpc",      {24'b0, fpc0}, 32'h42);
    seen = if0.mem_start;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (if0.mem_start) seen = 1'b1;
    end
    chk("t5_no_start", {31'b0, seen}, 0);
    en0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_resume_start", {31'b0, if0.mem_start}, 1);
    chk("t5_resume_addr",  {24'b0, if0.mem_address}, 32'h42);

    // Test 4: RESET_PC = FE wraps through FF to 00.
    exp_pc   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_data = '{8'h0E, 8'h0F, 8'h10, 8'h11};
    rst1 = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(posedge clk);
      #1;
      if (if1.byte_valid) begin
        got_pc[n]   = if1.byte_pc;
        got_data[n] = if1.byte_out;
        n++;
      end
    end
    chk("t4_count", n, 4);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("t4_pc%0d", k),   {24'b0, got_pc[k]},   {24'b0, exp_pc[k]});
      chk($sformatf("t4_data%0d", k), {24'b0, got_data[k]}, {24'b0, exp_data[k]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
